// File: rtl/wb_arb_if.sv
// wb_arb_if: writeback bus bundle carrying the pipeline write (A),
// the multi-cycle result handshake (B) and the register-file write port.
interface wb_arb_if;
    logic        a_we;
    logic [4:0]  a_rw;
    logic [31:0] a_rd;
    logic        b_valid;
    logic [4:0]  b_rw;
    logic [31:0] b_rd;
    logic        b_ready;
    logic        rf_we;
    logic [4:0]  rf_rw;
    logic [31:0] rf_rd;

    modport master (
        output a_we, a_rw, a_rd,
        output b_valid, b_rw, b_rd,
        input  b_ready,
        input  rf_we, rf_rw, rf_rd
    );

    modport slave (
        input  a_we, a_rw, a_rd,
        input  b_valid, b_rw, b_rd,
        output b_ready,
        output rf_we, rf_rw, rf_rd
    );
endinterface

// File: rtl/wb_arb.sv
// wb_arb: arbitrates the register-file write port between pipeline writes
// and buffered multi-cycle results, tracking pending destinations.
module wb_arb #(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    wb_arb_if.slave       wb,
    input  logic          iss_valid,
    input  logic [4:0]    iss_rw,
    input  logic [4:0]    ra,
    input  logic [4:0]    rb,
    output logic          stall,
    output logic [CW-1:0] b_count,
    output logic          err_waw
);

    logic [4:0]    buf_rw [DEPTH];
    logic [31:0]   buf_rd [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [31:0]   pending;
    logic [31:0]   pend_nxt;
    logic          a_hit;
    logic          push;
    logic          pop;
    logic [4:0]    head_rw;
    logic [31:0]   head_rd;

    assign a_hit   = wb.a_we && (wb.a_rw != 5'd0);
    // gated by reset so b_ready is low throughout reset, high on release
    assign wb.b_ready = reset && (count < CW'(DEPTH));
    assign push    = wb.b_valid && wb.b_ready && (wb.b_rw != 5'd0);
    assign pop     = !a_hit && (count != '0);
    assign head_rw = buf_rw[rd_ptr];
    assign head_rd = buf_rd[rd_ptr];
    assign b_count = count;

    assign stall = ((ra != 5'd0) && pending[ra]) ||
                   ((rb != 5'd0) && pending[rb]);

    always_comb begin
        pend_nxt = pending;
        if (pop)
            pend_nxt[head_rw] = 1'b0;
        if (iss_valid && (iss_rw != 5'd0))
            pend_nxt[iss_rw] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            buf_rw[wr_ptr] <= wb.b_rw;
            buf_rd[wr_ptr] <= wb.b_rd;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            pending  <= '0;
            err_waw  <= 1'b0;
            wb.rf_we <= 1'b0;
            wb.rf_rw <= 5'd0;
            wb.rf_rd <= 32'd0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            count   <= count + CW'(push) - CW'(pop);
            pending <= pend_nxt;
            if (a_hit && pending[wb.a_rw])
                err_waw <= 1'b1;
            wb.rf_we <= a_hit || pop;
            if (a_hit) begin
                wb.rf_rw <= wb.a_rw;
                wb.rf_rd <= wb.a_rd;
            end else if (pop) begin
                wb.rf_rw <= head_rw;
                wb.rf_rd <= head_rd;
            end
        end
    end

endmodule

// File: tb/tb_wb_arb.sv
// tb_wb_arb: directed scenarios plus randomized traffic checked against
// a queue-based model of the arbiter and scoreboard.
module tb_wb_arb;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [4:0]  rw;
        logic [31:0] rd;
    } ent_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       iss_valid;
    logic [4:0] iss_rw;
    logic [4:0] ra;
    logic [4:0] rb;
    logic       stall;
    logic [2:0] b_count;
    logic       err_waw;

    int pass_cnt = 0;
    int total    = 0;

    ent_t        mq[$];
    logic [31:0] m_pend;
    logic        m_we;
    logic [4:0]  m_rw;
    logic [31:0] m_rd;
    logic        m_err;

    wb_arb_if bus();

    wb_arb #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .wb        (bus),
        .iss_valid (iss_valid),
        .iss_rw    (iss_rw),
        .ra        (ra),
        .rb        (rb),
        .stall     (stall),
        .b_count   (b_count),
        .err_waw   (err_waw)
    );

    always #5 clk = ~clk;

    task automatic idle();
        bus.a_we    = 1'b0;
        bus.a_rw    = 5'd0;
        bus.a_rd    = 32'd0;
        bus.b_valid = 1'b0;
        bus.b_rw    = 5'd0;
        bus.b_rd    = 32'd0;
        iss_valid   = 1'b0;
        iss_rw      = 5'd0;
        ra          = 5'd0;
        rb          = 5'd0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // advance the model by one clock using the inputs currently applied
    function automatic void model_step();
        ent_t e;
        bit   rdy;
        rdy  = (mq.size() < DEPTH);
        m_we = 1'b0;
        if (bus.a_we && bus.a_rw != 5'd0) begin
            if (m_pend[bus.a_rw])
                m_err = 1'b1;
            m_we = 1'b1;
            m_rw = bus.a_rw;
            m_rd = bus.a_rd;
        end else if (mq.size() > 0) begin
            e    = mq.pop_front();
            m_we = 1'b1;
            m_rw = e.rw;
            m_rd = e.rd;
            m_pend[e.rw] = 1'b0;
        end
        if (bus.b_valid && rdy && bus.b_rw != 5'd0)
            mq.push_back({bus.b_rw, bus.b_rd});
        if (iss_valid && iss_rw != 5'd0)
            m_pend[iss_rw] = 1'b1;
    endfunction

    task automatic test_reset();
        idle();
        reset = 1'b0;
        tick();
        tick();
        total++;
        if ({bus.rf_we, bus.rf_rw, bus.rf_rd} !== 38'd0)
            $display("FAIL reset_rf got %0b/%0d/%h want 0/0/0",
                     bus.rf_we, bus.rf_rw, bus.rf_rd);
        else pass_cnt++;
        total++;
        if ({b_count, bus.b_ready, err_waw, stall} !== 6'd0)
            $display("FAIL reset_ctl got cnt=%0d rdy=%0b err=%0b st=%0b want 0",
                     b_count, bus.b_ready, err_waw, stall);
        else pass_cnt++;
        #2 reset = 1'b1;
        #1;
        total++;
        if (bus.b_ready !== 1'b1)
            $display("FAIL reset_release_ready got %0b want 1", bus.b_ready);
        else pass_cnt++;
    endtask

    task automatic test_a_only();
        idle();
        bus.a_we = 1'b1;
        bus.a_rw = 5'd5;
        bus.a_rd = 32'hDEADBEEF;
        tick();
        bus.a_we = 1'b0;
        total++;
        if ({bus.rf_we, bus.rf_rw, bus.rf_rd} !== {1'b1, 5'd5, 32'hDEADBEEF})
            $display("FAIL a_only got %0b/%0d/%h want 1/5/deadbeef",
                     bus.rf_we, bus.rf_rw, bus.rf_rd);
        else pass_cnt++;
        tick();
        total++;
        if ({bus.rf_we, bus.rf_rw, bus.rf_rd} !== {1'b0, 5'd5, 32'hDEADBEEF})
            $display("FAIL a_only_hold got %0b/%0d/%h want 0/5/deadbeef",
                     bus.rf_we, bus.rf_rw, bus.rf_rd);
        else pass_cnt++;
        bus.a_we = 1'b1;
        bus.a_rw = 5'd0;
        bus.a_rd = 32'h1234;
        tick();
        bus.a_we = 1'b0;
        total++;
        if (bus.rf_we !== 1'b0 || bus.rf_rd !== 32'hDEADBEEF)
            $display("FAIL a_r0_ignored got we=%0b rd=%h want 0/deadbeef",
                     bus.rf_we, bus.rf_rd);
        else pass_cnt++;
    endtask

    task automatic test_contention();
        idle();
        bus.a_we    = 1'b1;
        bus.a_rw    = 5'd3;
        bus.a_rd    = 32'h33;
        bus.b_valid = 1'b1;
        bus.b_rw    = 5'd7;
        bus.b_rd    = 32'h11;
        for (int i = 0; i < 3; i++) begin
            tick();
            bus.b_valid = 1'b0;
            total++;
            if (bus.rf_we !== 1'b1 || bus.rf_rw !== 5'd3 || b_count !== 3'd1)
                $display("FAIL contention_a%0d got we=%0b rw=%0d cnt=%0d want 1/3/1",
                         i, bus.rf_we, bus.rf_rw, b_count);
            else pass_cnt++;
        end
        bus.a_we = 1'b0;
        tick();
        total++;
        if ({bus.rf_we, bus.rf_rw, bus.rf_rd} !== {1'b1, 5'd7, 32'h11} ||
            b_count !== 3'd0)
            $display("FAIL contention_pop got %0b/%0d/%h cnt=%0d want 1/7/11 cnt=0",
                     bus.rf_we, bus.rf_rw, bus.rf_rd, b_count);
        else pass_cnt++;
        bus.a_we    = 1'b1;
        bus.a_rw    = 5'd0;
        bus.b_valid = 1'b1;
        bus.b_rw    = 5'd0;
        bus.b_rd    = 32'h5A;
        tick();
        idle();
        total++;
        if (bus.rf_we !== 1'b0 || b_count !== 3'd0)
            $display("FAIL b_r0_discard got we=%0b cnt=%0d want 0/0",
                     bus.rf_we, b_count);
        else pass_cnt++;
    endtask

    task automatic test_full();
        idle();
        bus.a_we = 1'b1;
        bus.a_rw = 5'd2;
        bus.a_rd = 32'h22;
        for (int i = 0; i < 4; i++) begin
            bus.b_valid = 1'b1;
            bus.b_rw    = 5'(10 + i);
            bus.b_rd    = 32'h100 + 32'(i);
            tick();
        end
        bus.b_rw = 5'd20;
        bus.b_rd = 32'hBAD;
        #1;
        total++;
        if (b_count !== 3'd4 || bus.b_ready !== 1'b0)
            $display("FAIL full got cnt=%0d rdy=%0b want 4/0", b_count, bus.b_ready);
        else pass_cnt++;
        tick();
        bus.b_valid = 1'b0;
        total++;
        if (b_count !== 3'd4)
            $display("FAIL full_reject got cnt=%0d want 4", b_count);
        else pass_cnt++;
        bus.a_we = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if (bus.rf_we !== 1'b1 || bus.rf_rw !== 5'(10 + i) ||
                bus.rf_rd !== 32'h100 + 32'(i) || b_count !== 3'(3 - i))
                $display("FAIL full_pop%0d got %0b/%0d/%h cnt=%0d want 1/%0d/%h cnt=%0d",
                         i, bus.rf_we, bus.rf_rw, bus.rf_rd, b_count,
                         10 + i, 32'h100 + 32'(i), 3 - i);
            else pass_cnt++;
            if (i == 0) begin
                total++;
                if (bus.b_ready !== 1'b1)
                    $display("FAIL full_ready_rise got %0b want 1", bus.b_ready);
                else pass_cnt++;
            end
        end
        tick();
        total++;
        if (bus.rf_we !== 1'b0)
            $display("FAIL full_drained got we=%0b want 0", bus.rf_we);
        else pass_cnt++;
    endtask

    task automatic test_scoreboard();
        idle();
        iss_valid = 1'b1;
        iss_rw    = 5'd9;
        tick();
        iss_valid = 1'b0;
        ra = 5'd9;
        #1;
        total++;
        if (stall !== 1'b1)
            $display("FAIL sb_stall_ra got %0b want 1", stall);
        else pass_cnt++;
        ra = 5'd0;
        rb = 5'd9;
        #1;
        total++;
        if (stall !== 1'b1)
            $display("FAIL sb_stall_rb got %0b want 1", stall);
        else pass_cnt++;
        rb = 5'd0;
        #1;
        total++;
        if (stall !== 1'b0)
            $display("FAIL sb_r0 got %0b want 0", stall);
        else pass_cnt++;
        ra = 5'd9;
        bus.b_valid = 1'b1;
        bus.b_rw    = 5'd9;
        bus.b_rd    = 32'h99;
        tick();
        bus.b_valid = 1'b0;
        total++;
        if (stall !== 1'b1 || bus.rf_we !== 1'b0)
            $display("FAIL sb_accepted got st=%0b we=%0b want 1/0", stall, bus.rf_we);
        else pass_cnt++;
        tick();
        total++;
        if (bus.rf_we !== 1'b1 || bus.rf_rw !== 5'd9 || stall !== 1'b0)
            $display("FAIL sb_clear got we=%0b rw=%0d st=%0b want 1/9/0",
                     bus.rf_we, bus.rf_rw, stall);
        else pass_cnt++;
        // same-register set and clear in one cycle: set wins
        iss_valid = 1'b1;
        iss_rw    = 5'd6;
        tick();
        bus.b_valid = 1'b1;
        bus.b_rw    = 5'd6;
        bus.b_rd    = 32'h66;
        tick();
        bus.b_valid = 1'b0;
        tick();
        iss_valid = 1'b0;
        ra = 5'd6;
        #1;
        total++;
        if (bus.rf_rw !== 5'd6 || stall !== 1'b1)
            $display("FAIL sb_set_wins got rw=%0d st=%0b want 6/1", bus.rf_rw, stall);
        else pass_cnt++;
        idle();
    endtask

    task automatic test_hazard_reset();
        idle();
        iss_valid = 1'b1;
        iss_rw    = 5'd4;
        tick();
        iss_valid = 1'b0;
        total++;
        if (err_waw !== 1'b0)
            $display("FAIL waw_pre got %0b want 0", err_waw);
        else pass_cnt++;
        bus.a_we = 1'b1;
        bus.a_rw = 5'd4;
        bus.a_rd = 32'h4;
        tick();
        bus.a_rw = 5'd8;
        total++;
        if (err_waw !== 1'b1)
            $display("FAIL waw_set got %0b want 1", err_waw);
        else pass_cnt++;
        bus.b_valid = 1'b1;
        bus.b_rw    = 5'd12;
        bus.b_rd    = 32'hC;
        tick();
        tick();
        total++;
        if (err_waw !== 1'b1 || b_count !== 3'd2)
            $display("FAIL waw_sticky got err=%0b cnt=%0d want 1/2", err_waw, b_count);
        else pass_cnt++;
        ra = 5'd4;
        #2 reset = 1'b0;
        #1;
        total++;
        if ({bus.rf_we, bus.rf_rw, bus.rf_rd} !== 38'd0 || b_count !== 3'd0 ||
            bus.b_ready !== 1'b0 || err_waw !== 1'b0 || stall !== 1'b0)
            $display("FAIL mid_reset got %0b/%0d/%h cnt=%0d rdy=%0b err=%0b st=%0b want all 0",
                     bus.rf_we, bus.rf_rw, bus.rf_rd, b_count, bus.b_ready,
                     err_waw, stall);
        else pass_cnt++;
        idle();
        tick();
        reset = 1'b1;
        tick();
        total++;
        if (bus.rf_we !== 1'b0 || b_count !== 3'd0)
            $display("FAIL post_reset_discard got we=%0b cnt=%0d want 0/0",
                     bus.rf_we, b_count);
        else pass_cnt++;
    endtask

    task automatic test_random();
        mq.delete();
        m_pend = '0;
        m_we   = 1'b0;
        m_rw   = 5'd0;
        m_rd   = 32'd0;
        m_err  = 1'b0;
        for (int c = 0; c < 400; c++) begin
            bus.a_we    = ($urandom_range(0, 99) < 45);
            bus.a_rw    = 5'($urandom_range(0, 7));
            bus.a_rd    = $urandom;
            bus.b_valid = ($urandom_range(0, 99) < 55);
            bus.b_rw    = 5'($urandom_range(0, 7));
            bus.b_rd    = $urandom;
            iss_valid   = ($urandom_range(0, 99) < 25);
            iss_rw      = 5'($urandom_range(0, 7));
            ra          = 5'($urandom_range(0, 7));
            rb          = 5'($urandom_range(0, 7));
            #1;
            total++;
            if (bus.b_ready !== (mq.size() < DEPTH) ||
                stall !== ((ra != 0 && m_pend[ra]) || (rb != 0 && m_pend[rb])))
                $display("FAIL rnd_comb c=%0d got rdy=%0b st=%0b want rdy=%0b st=%0b",
                         c, bus.b_ready, stall, mq.size() < DEPTH,
                         (ra != 0 && m_pend[ra]) || (rb != 0 && m_pend[rb]));
            else pass_cnt++;
            model_step();
            tick();
            total++;
            if ({bus.rf_we, bus.rf_rw, bus.rf_rd} !== {m_we, m_rw, m_rd} ||
                b_count !== 3'(mq.size()) || err_waw !== m_err)
                $display("FAIL rnd_seq c=%0d got %0b/%0d/%h cnt=%0d err=%0b want %0b/%0d/%h cnt=%0d err=%0b",
                         c, bus.rf_we, bus.rf_rw, bus.rf_rd, b_count, err_waw,
                         m_we, m_rw, m_rd, mq.size(), m_err);
            else pass_cnt++;
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_a_only();
        test_contention();
        test_full();
        test_scoreboard();
        test_hazard_reset();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
